outer_product_n: RTL and testbench

Parametrised streaming outer-product kernel for a PR-flow leaf user slot; generalises the fixed outer_product2 kernel to run-time vector length, selectable product bit-slice and signedness. A config word on Input_1 sets up a job; vectors A (Input_2) and B (Input_3) are buffered concurrently; then n×n products are emitted row-major on Output_1. It connects to leaf_interface user ports exactly as the existing kernel does (32-bit payload, ap_vld/ap_ack streams).

---
 rtl/outer_product_pkg.sv | 25 ++
 rtl/op_vec_buf.sv | 50 +++++
 rtl/outer_product_n.sv | 167 ++++++++++++++++
 tb/tb_outer_product_n.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/outer_product_pkg.sv
// Shared types, config-word field positions and config clamping for outer_product_n.
package outer_product_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EMIT = 2'd2
    } state_e;

    localparam int N_LSB      = 0;
    localparam int SHIFT_LSB  = 8;
    localparam int SIGNED_BIT = 16;

    // A zero or oversized length means "use the full buffer".
    function automatic logic [7:0] clamp_n(input logic [7:0] n, input int len);
        if (n == 8'd0 || int'(n) > len) return 8'(len);
        return n;
    endfunction

    function automatic logic [7:0] clamp_shift(input logic [7:0] sh, input int width);
        if (int'(sh) > width) return 8'(width);
        return sh;
    endfunction

endpackage

// File: rtl/op_vec_buf.sv
// Vector buffer: accepts up to n_i words while loading, then serves random reads.
module op_vec_buf
    import outer_product_pkg::*;
#(
    parameter int DATA_BITS = 32,
    parameter int LEN       = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 load_i,
    input  logic [7:0]           n_i,
    input  logic                 wr_vld_i,
    input  logic [DATA_BITS-1:0] wr_data_i,
    output logic                 wr_ack_o,
    output logic                 full_o,
    input  logic [7:0]           rd_idx_i,
    output logic [DATA_BITS-1:0] rd_data_o
);

    localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;

    logic [DATA_BITS-1:0] mem_q [LEN];
    logic [7:0]           cnt_q, cnt_d;
    logic                 wr;
    logic                 unused_idx;

    assign wr_ack_o   = load_i && (cnt_q < n_i);
    assign wr         = wr_ack_o && wr_vld_i;
    // full_o reports the count after this edge so the FSM can leave LOAD on the last write.
    assign full_o     = (cnt_d == n_i);
    assign rd_data_o  = mem_q[rd_idx_i[IW-1:0]];
    assign unused_idx = ^rd_idx_i;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)   cnt_d = 8'd0;
        else if (wr) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= 8'd0;
        else       cnt_q <= cnt_d;
    end

    always_ff @(posedge clk_i) begin
        if (wr) mem_q[cnt_q[IW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/outer_product_n.sv
// Streaming outer product: config word, buffered A/B vectors, n*n sliced products row-major.
module outer_product_n
    import outer_product_pkg::*;
#(
    parameter int DATA_BITS = 32,
    parameter int LEN       = 16
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 ap_start,
    output logic                 ap_done,
    output logic                 ap_ready,
    output logic                 ap_idle,
    input  logic [DATA_BITS-1:0] Input_1_V_V,
    input  logic                 Input_1_V_V_ap_vld,
    output logic                 Input_1_V_V_ap_ack,
    input  logic [DATA_BITS-1:0] Input_2_V_V,
    input  logic                 Input_2_V_V_ap_vld,
    output logic                 Input_2_V_V_ap_ack,
    input  logic [DATA_BITS-1:0] Input_3_V_V,
    input  logic                 Input_3_V_V_ap_vld,
    output logic                 Input_3_V_V_ap_ack,
    output logic [DATA_BITS-1:0] Output_1_V_V,
    output logic                 Output_1_V_V_ap_vld,
    input  logic                 Output_1_V_V_ap_ack
);

    localparam int PW = 2 * DATA_BITS;

    state_e               state_q, state_d;
    logic [7:0]           n_q, n_d, shift_q, shift_d;
    logic                 sgn_q, sgn_d;
    logic [7:0]           i_q, i_d, j_q, j_d;
    logic                 issued_q, issued_d, last_q, last_d, done_q, done_d;
    logic                 vld_q, vld_d;
    logic [DATA_BITS-1:0] out_q, out_d;
    logic                 cfg_ack, load, clr, a_full, b_full, out_xfer, can_load, is_last;
    logic [DATA_BITS-1:0] a_rd, b_rd;
    logic signed [PW-1:0] prod_s;
    logic [PW-1:0]        prod_u, prod;
    logic                 unused_cfg;

    // Sign/zero-extend the full product past its top, then take the DATA_BITS window at sh.
    function automatic logic [DATA_BITS-1:0] slice_prod(input logic [PW-1:0] p,
                                                        input logic sgn, input logic [7:0] sh);
        logic [3*DATA_BITS-1:0] ext;
        ext = {{DATA_BITS{sgn & p[PW-1]}}, p};
        ext = ext >> sh;
        return ext[DATA_BITS-1:0];
    endfunction

    op_vec_buf #(.DATA_BITS(DATA_BITS), .LEN(LEN)) u_buf_a (
        .clk_i(ap_clk), .rst_i(ap_rst), .clr_i(clr), .load_i(load), .n_i(n_q),
        .wr_vld_i(Input_2_V_V_ap_vld), .wr_data_i(Input_2_V_V), .wr_ack_o(Input_2_V_V_ap_ack),
        .full_o(a_full), .rd_idx_i(i_q), .rd_data_o(a_rd)
    );

    op_vec_buf #(.DATA_BITS(DATA_BITS), .LEN(LEN)) u_buf_b (
        .clk_i(ap_clk), .rst_i(ap_rst), .clr_i(clr), .load_i(load), .n_i(n_q),
        .wr_vld_i(Input_3_V_V_ap_vld), .wr_data_i(Input_3_V_V), .wr_ack_o(Input_3_V_V_ap_ack),
        .full_o(b_full), .rd_idx_i(j_q), .rd_data_o(b_rd)
    );

    assign prod_s = $signed({{DATA_BITS{a_rd[DATA_BITS-1]}}, a_rd})
                  * $signed({{DATA_BITS{b_rd[DATA_BITS-1]}}, b_rd});
    assign prod_u = {{DATA_BITS{1'b0}}, a_rd} * {{DATA_BITS{1'b0}}, b_rd};
    assign prod   = sgn_q ? prod_s : prod_u;

    assign out_xfer = vld_q && Output_1_V_V_ap_ack;
    assign can_load = !vld_q || Output_1_V_V_ap_ack;
    assign is_last  = (i_q == n_q - 8'd1) && (j_q == n_q - 8'd1);

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        shift_d  = shift_q;
        sgn_d    = sgn_q;
        i_d      = i_q;
        j_d      = j_q;
        issued_d = issued_q;
        last_d   = last_q;
        vld_d    = vld_q;
        out_d    = out_q;
        done_d   = 1'b0;
        cfg_ack  = 1'b0;
        load     = 1'b0;
        clr      = 1'b0;
        case (state_q)
            S_IDLE: begin
                cfg_ack = ap_start;
                if (ap_start && Input_1_V_V_ap_vld) begin
                    n_d      = clamp_n(Input_1_V_V[N_LSB +: 8], LEN);
                    shift_d  = clamp_shift(Input_1_V_V[SHIFT_LSB +: 8], DATA_BITS);
                    sgn_d    = Input_1_V_V[SIGNED_BIT];
                    i_d      = 8'd0;
                    j_d      = 8'd0;
                    issued_d = 1'b0;
                    clr      = 1'b1;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                load = 1'b1;
                if (a_full && b_full) state_d = S_EMIT;
            end
            S_EMIT: begin
                if (out_xfer) vld_d = 1'b0;
                if (out_xfer && last_q) begin
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (can_load && !issued_q) begin
                    // Refill on the same edge as the ack so a held-high ack sees no bubbles.
                    out_d  = slice_prod(prod, sgn_q, shift_q);
                    vld_d  = 1'b1;
                    last_d = is_last;
                    if (is_last) issued_d = 1'b1;
                    if (j_q == n_q - 8'd1) begin
                        j_d = 8'd0;
                        i_d = i_q + 8'd1;
                    end else begin
                        j_d = j_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q  <= S_IDLE;
            i_q      <= 8'd0;
            j_q      <= 8'd0;
            issued_q <= 1'b0;
            last_q   <= 1'b0;
            vld_q    <= 1'b0;
            out_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            issued_q <= issued_d;
            last_q   <= last_d;
            vld_q    <= vld_d;
            out_q    <= out_d;
            done_q   <= done_d;
        end
    end

    // Job configuration is only meaningful after a config transfer, so it carries no reset.
    always_ff @(posedge ap_clk) begin
        n_q     <= n_d;
        shift_q <= shift_d;
        sgn_q   <= sgn_d;
    end

    assign Input_1_V_V_ap_ack  = cfg_ack;
    assign Output_1_V_V        = out_q;
    assign Output_1_V_V_ap_vld = vld_q;
    assign ap_done             = done_q;
    assign ap_ready            = done_q;
    assign ap_idle             = (state_q == S_IDLE);
    assign unused_cfg          = ^Input_1_V_V;

endmodule

// File: tb/tb_outer_product_n.sv
// Directed bench for outer_product_n: fixed jobs with hand-computed product sequences.
module tb_outer_product_n;

    logic        ap_clk = 1'b0;
    logic        ap_rst, ap_start;
    logic        ap_done, ap_ready, ap_idle;
    logic [31:0] in1_data, in2_data, in3_data, out_data;
    logic        in1_vld, in2_vld, in3_vld, out_ack;
    logic        in1_ack, in2_ack, in3_ack, out_vld;

    int          checks   = 0;
    int          failures = 0;

    logic [31:0] a_vec   [0:255];
    logic [31:0] b_vec   [0:255];
    logic [31:0] exp_vec [0:1023];

    always #5 ap_clk = ~ap_clk;

    outer_product_n #(.DATA_BITS(32), .LEN(16)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
        .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle),
        .Input_1_V_V(in1_data), .Input_1_V_V_ap_vld(in1_vld), .Input_1_V_V_ap_ack(in1_ack),
        .Input_2_V_V(in2_data), .Input_2_V_V_ap_vld(in2_vld), .Input_2_V_V_ap_ack(in2_ack),
        .Input_3_V_V(in3_data), .Input_3_V_V_ap_vld(in3_vld), .Input_3_V_V_ap_ack(in3_ack),
        .Output_1_V_V(out_data), .Output_1_V_V_ap_vld(out_vld), .Output_1_V_V_ap_ack(out_ack)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One job: send cfg, stream A (vld always high, extra words must stay pending) and B
    // (delayed by b_delay cycles), consume stop_at outputs, compare each against exp_vec.
    task automatic run_job(input logic [31:0] cfg, input int na, input int total,
                           input int stop_at, input int b_delay, input bit toggle,
                           input int exp_first, input string tag);
        int ai, bi, oi, cyc, first_c, last_c, dones;
        bit early, over, held_v, timeout;
        logic [31:0] held;
        ai = 0; bi = 0; oi = 0; cyc = 0; first_c = -1; last_c = -1; dones = 0;
        early = 0; over = 0; held_v = 0; timeout = 0; held = '0;
        @(negedge ap_clk);
        ap_start = 1'b1; in1_data = cfg; in1_vld = 1'b1;
        #1 check({tag, "_cfg_ack"}, in1_ack, 1'b1);
        @(posedge ap_clk);
        @(negedge ap_clk);
        ap_start = 1'b0; in1_vld = 1'b0;
        while (oi < stop_at) begin
            if (cyc >= 3000) begin
                timeout = 1;
                break;
            end
            in2_vld  = 1'b1;
            in2_data = (ai < na) ? a_vec[ai] : 32'hDEAD_BEEF;
            in3_vld  = (cyc >= b_delay);
            in3_data = (bi < na) ? b_vec[bi] : 32'hBAD0_0000;
            out_ack  = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (held_v) begin
                check({tag, "_hold_vld"}, out_vld, 1'b1);
                check({tag, "_hold_data"}, out_data, held);
            end
            if (out_vld && first_c < 0) first_c = cyc;
            if (out_vld && bi < na) early = 1;
            if (in2_ack && ai >= na) over = 1;
            if (in3_vld && in3_ack && bi >= na) over = 1;
            if (ap_done) dones++;
            held_v = 0;
            if (out_vld && out_ack) begin
                check({tag, "_out"}, out_data, exp_vec[oi]);
                oi++;
                last_c = cyc;
            end else if (out_vld) begin
                held_v = 1;
                held   = out_data;
            end
            if (in2_ack) ai++;
            if (in3_vld && in3_ack) bi++;
            @(posedge ap_clk);
            @(negedge ap_clk);
            cyc++;
        end
        in2_vld = 1'b0; in3_vld = 1'b0;
        check({tag, "_timeout"}, timeout, 1'b0);
        check({tag, "_early_vld"}, early, 1'b0);
        check({tag, "_extra_ack"}, over, 1'b0);
        if (exp_first >= 0) check({tag, "_first_lat"}, first_c, exp_first);
        if (stop_at == total && !timeout) begin
            check({tag, "_no_early_done"}, dones, 0);
            if (!toggle) check({tag, "_throughput"}, last_c - first_c, total - 1);
            check({tag, "_done"}, {ap_done, ap_ready, ap_idle}, 3'b111);
            out_ack = 1'b0;
            @(negedge ap_clk);
            check({tag, "_done_pulse"}, ap_done, 1'b0);
        end
    endtask

    initial begin
        ap_rst = 1'b1; ap_start = 1'b0;
        in1_vld = 1'b0; in2_vld = 1'b0; in3_vld = 1'b0; out_ack = 1'b0;
        in1_data = '0; in2_data = '0; in3_data = '0;
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        check("rst_idle", ap_idle, 1'b1);
        check("rst_out", {out_vld, out_data}, 33'h0);
        check("rst_acks", {in1_ack, in2_ack, in3_ack}, 3'b000);
        check("rst_done", {ap_done, ap_ready}, 2'b00);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        check("idle_ack_low", in1_ack, 1'b0);
        ap_start = 1'b1;
        #1 check("idle_ack_tracks", in1_ack, 1'b1);
        ap_start = 1'b0;

        // n=2 unsigned, ack held high
        a_vec[0] = 32'd2; a_vec[1] = 32'd3; b_vec[0] = 32'd5; b_vec[1] = 32'd7;
        exp_vec[0] = 32'd10; exp_vec[1] = 32'd14; exp_vec[2] = 32'd15; exp_vec[3] = 32'd21;
        run_job(32'h0000_0002, 2, 4, 4, 0, 1'b0, 3, "n2");

        // same job with output ack toggling
        run_job(32'h0000_0002, 2, 4, 4, 0, 1'b1, 3, "n2_tog");

        // n=1 signed shift 4: -16*3 = -48, >>4 = -3
        a_vec[0] = 32'hFFFF_FFF0; b_vec[0] = 32'd3; exp_vec[0] = 32'hFFFF_FFFD;
        run_job(32'h0001_0401, 1, 1, 1, 0, 1'b0, 2, "n1_sgn");

        // shift 200 clamps to 32: (2^32-1)^2 upper word
        a_vec[0] = 32'hFFFF_FFFF; b_vec[0] = 32'hFFFF_FFFF; exp_vec[0] = 32'hFFFF_FFFE;
        run_job(32'h0000_C801, 1, 1, 1, 0, 1'b0, 2, "shift_clamp");

        // n=0 clamps to LEN=16: A_i=i+1, B_j=1
        for (int i = 0; i < 16; i++) begin
            a_vec[i] = i + 1;
            b_vec[i] = 32'd1;
            for (int j = 0; j < 16; j++) exp_vec[i*16 + j] = i + 1;
        end
        run_job(32'h0000_0000, 16, 256, 256, 0, 1'b0, 17, "n0");

        // A fed 5 cycles before B
        a_vec[0] = 32'd1; a_vec[1] = 32'd2; a_vec[2] = 32'd3;
        b_vec[0] = 32'd4; b_vec[1] = 32'd5; b_vec[2] = 32'd6;
        exp_vec[0] = 32'd4;  exp_vec[1] = 32'd5;  exp_vec[2] = 32'd6;
        exp_vec[3] = 32'd8;  exp_vec[4] = 32'd10; exp_vec[5] = 32'd12;
        exp_vec[6] = 32'd12; exp_vec[7] = 32'd15; exp_vec[8] = 32'd18;
        run_job(32'h0000_0003, 3, 9, 9, 5, 1'b0, -1, "b_late");

        // n=3 job abandoned by reset after 4 outputs
        run_job(32'h0000_0003, 3, 9, 4, 0, 1'b0, -1, "abort");
        ap_rst = 1'b1; out_ack = 1'b0;
        @(posedge ap_clk);
        #1;
        check("abort_vld", out_vld, 1'b0);
        check("abort_idle", ap_idle, 1'b1);
        check("abort_data", out_data, 32'h0);
        @(negedge ap_clk);
        ap_rst = 1'b0;

        // fresh n=2 job after reset
        a_vec[0] = 32'd6; a_vec[1] = 32'd7; b_vec[0] = 32'd8; b_vec[1] = 32'd9;
        exp_vec[0] = 32'd48; exp_vec[1] = 32'd54; exp_vec[2] = 32'd56; exp_vec[3] = 32'd63;
        run_job(32'h0000_0002, 2, 4, 4, 0, 1'b0, 3, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
